hsv_div_sched: RTL
==================

HSV_DIV_SCHED -- requirements
Module: hsv_div_sched

Interface
REQ-001 Parameter N_REQ, default 3, SHALL set the number of requesters sharing one divider (range 2..4).
REQ-002 Parameter DW, default 10, SHALL set the dividend, divisor, quotient and fractional width in bits.
REQ-003 Parameter LAT, default 4, SHALL set the fixed latency of the external divider, in ce-qualified cycles from issue to result (range 1..16).
REQ-004 Port list (one clock; reset is asynchronous and active-high):
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ce  in  1  clock enable; stalls the whole block when low
- req  in  N_REQ  per-requester request, level, held until granted
- dividend_in  in  N_REQ*DW  requester i operand in slice [i*DW +: DW]
- divisor_in  in  N_REQ*DW  requester i operand in slice [i*DW +: DW]
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- div_ce  out  1  enable to the external divider, equals ce
- div_dividend  out  DW  operand issued to the divider
- div_divisor  out  DW  operand issued to the divider
- div_quotient  in  DW  divider result
- div_fractional  in  DW  divider result
- res_valid  out  N_REQ  one-hot, one-cycle result strobe naming the owner
- res_quotient  out  DW  returned quotient
- res_fractional  out  DW  returned fractional part
- res_dbz  out  1  returned result came from a zero divisor
- busy  out  1  at least one operation in flight
- inflight  out  5  count of operations in flight

Function
REQ-005 On each ce=1 cycle with any req bit set, the block SHALL grant exactly one requester, chosen round-robin starting after the last granted index.
REQ-006 After reset, the round-robin pointer SHALL give requester 0 the highest priority.
REQ-007 A grant SHALL assert gnt[i] for that single cycle and register dividend_in/divisor_in slice i onto div_dividend/div_divisor in the same clock edge.
REQ-008 A requester SHALL see gnt[i] as consumption of its operands; it may drop req or present new operands on the next cycle.
REQ-009 With ce=0, the block SHALL hold gnt at 0, freeze the issue registers, tag pipeline, pointer and counters, and drive res_valid to 0.
REQ-010 Each issue SHALL push a tag {valid, owner index, dbz} into a LAT-deep shift register that advances only when ce=1.
REQ-011 The tag pipeline SHALL be aligned so res_valid[owner] asserts on the clock edge where div_quotient/div_fractional carry that operation's result.
REQ-012 res_quotient/res_fractional SHALL be registered copies of div_quotient/div_fractional, giving a grant-to-res_valid latency of exactly LAT+1 ce-cycles.
REQ-013 A zero divisor SHALL still be issued and tagged with dbz=1.
REQ-014 For a dbz result, the block SHALL force res_quotient and res_fractional to 0 and assert res_dbz along with res_valid.
REQ-015 res_dbz SHALL be 0 whenever res_valid is 0.
REQ-016 Issue rate SHALL be one operation per ce-cycle sustained, with no bubbles while any req is high.
REQ-017 Results SHALL return in issue order.
REQ-018 inflight SHALL increment on issue and decrement on result.
REQ-019 An issue and a result in the same cycle SHALL leave inflight unchanged.
REQ-020 inflight SHALL never exceed LAT+1.
REQ-021 busy SHALL equal (inflight != 0).
REQ-022 The pointer SHALL wrap from N_REQ-1 to 0.
REQ-023 The pointer SHALL only advance on a grant.
REQ-024 A request bit for an index >= N_REQ does not exist and is not required to be handled.

Reset
REQ-025 rst=1 SHALL asynchronously clear to 0: gnt, res_valid, res_quotient, res_fractional, res_dbz, div_dividend, div_divisor, every tag valid bit, inflight and busy.
REQ-026 rst=1 SHALL asynchronously set the round-robin pointer to requester 0.
REQ-027 Operations in flight when rst asserts SHALL be discarded, and no res_valid SHALL assert for them after release.
REQ-028 The first grant SHALL occur on the first ce=1 rising edge after rst deasserts.

Verification
REQ-029 Single request, LAT=4: req=001, dividend=200, divisor=255 -> gnt=001 for one cycle, and res_valid=001 exactly 5 ce-cycles later with res_quotient/res_fractional equal to the divider model output for 200/255.
REQ-030 All three requesters held high for 9 cycles -> grants 001,010,100 repeated three times, results strobed in the same order, inflight peaks at 5, busy falls exactly 5 cycles after the last grant.
REQ-031 Zero divisor: req=010, divisor=0 -> res_valid=010 with res_dbz=1 and res_quotient=res_fractional=0.
REQ-032 ce toggled 1,0,0,1 during a burst -> no grant and no res_valid in the ce=0 cycles, and the grant-to-result distance counted in ce=1 cycles stays exactly 5.
REQ-033 rst pulsed while 3 operations are in flight -> all outputs read 0 immediately, no res_valid in the following 10 cycles, and the next grant goes to requester 0.
REQ-034 Grant after requester 2, then req=111 -> the next grant is 001 (wrap-around).

Source files
------------

// File: rtl/hsv_div_sched_if.sv
// hsv_div_sched_if: requester, divider and result signals of the shared-divider scheduler.
interface hsv_div_sched_if #(
    parameter int N_REQ = 3,
    parameter int DW = 10
);
    logic ce;
    logic [N_REQ-1:0] req;
    logic [N_REQ*DW-1:0] dividend_in;
    logic [N_REQ*DW-1:0] divisor_in;
    logic [N_REQ-1:0] gnt;
    logic div_ce;
    logic [DW-1:0] div_dividend;
    logic [DW-1:0] div_divisor;
    logic [DW-1:0] div_quotient;
    logic [DW-1:0] div_fractional;
    logic [N_REQ-1:0] res_valid;
    logic [DW-1:0] res_quotient;
    logic [DW-1:0] res_fractional;
    logic res_dbz;
    logic busy;
    logic [4:0] inflight;

    modport master (
        output ce, req, dividend_in, divisor_in, div_quotient, div_fractional,
        input gnt, div_ce, div_dividend, div_divisor, res_valid, res_quotient,
        res_fractional, res_dbz, busy, inflight
    );
    modport slave (
        input ce, req, dividend_in, divisor_in, div_quotient, div_fractional,
        output gnt, div_ce, div_dividend, div_divisor, res_valid, res_quotient,
        res_fractional, res_dbz, busy, inflight
    );
endinterface

// File: rtl/hsv_div_sched.sv
// hsv_div_sched: round-robin issue of N_REQ requesters onto one fixed-latency divider,
// with an owner/dbz tag pipeline that routes each result back in issue order.
module hsv_div_sched #(
    parameter int N_REQ = 3,
    parameter int DW = 10,
    parameter int LAT = 4
) (
    input logic clk,
    input logic rst,
    hsv_div_sched_if.slave bus
);
    localparam int IW = (N_REQ > 2) ? 2 : 1;

    logic [IW-1:0] ptr, sel, iss_own;
    logic [IW:0] j;
    logic hit, issue, retire, iss_v, iss_dbz;
    logic [DW-1:0] sel_a, sel_b;
    logic [LAT-1:0] tag_v, tag_dbz;
    logic [IW-1:0] tag_own [LAT];

    // ptr holds the highest-priority index; the lowest rotated distance wins
    always_comb begin
        sel = ptr;
        hit = 1'b0;
        j = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + (IW+1)'(k);
            j = (j >= (IW+1)'(N_REQ)) ? j - (IW+1)'(N_REQ) : j;
            if (bus.req[j[IW-1:0]]) begin
                hit = 1'b1;
                sel = j[IW-1:0];
            end
        end
    end

    assign sel_a = bus.dividend_in[int'(sel)*DW +: DW];
    assign sel_b = bus.divisor_in[int'(sel)*DW +: DW];
    assign issue = bus.ce & hit;
    assign retire = bus.ce & tag_v[LAT-1];
    assign bus.div_ce = bus.ce;
    assign bus.busy = |bus.inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            bus.gnt <= '0;
            bus.res_valid <= '0;
            bus.res_quotient <= '0;
            bus.res_fractional <= '0;
            bus.res_dbz <= 1'b0;
            bus.div_dividend <= '0;
            bus.div_divisor <= '0;
            bus.inflight <= '0;
            iss_v <= 1'b0;
            iss_own <= '0;
            iss_dbz <= 1'b0;
            tag_v <= '0;
            tag_dbz <= '0;
            for (int s = 0; s < LAT; s++) tag_own[s] <= '0;
        end else begin
            bus.gnt <= issue ? N_REQ'(1) << sel : '0;
            bus.res_valid <= retire ? N_REQ'(1) << tag_own[LAT-1] : '0;
            bus.res_dbz <= retire & tag_dbz[LAT-1];
            if (bus.ce) begin
                if (hit) begin
                    bus.div_dividend <= sel_a;
                    bus.div_divisor <= sel_b;
                    ptr <= (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
                end
                // issue tag sits beside the operand registers, so the divider sees both on the same edge
                iss_v <= hit;
                iss_own <= sel;
                iss_dbz <= (sel_b == '0);
                tag_v[0] <= iss_v;
                tag_own[0] <= iss_own;
                tag_dbz[0] <= iss_dbz;
                for (int s = LAT - 1; s > 0; s--) begin
                    tag_v[s] <= tag_v[s-1];
                    tag_own[s] <= tag_own[s-1];
                    tag_dbz[s] <= tag_dbz[s-1];
                end
                if (retire) begin
                    bus.res_quotient <= tag_dbz[LAT-1] ? '0 : bus.div_quotient;
                    bus.res_fractional <= tag_dbz[LAT-1] ? '0 : bus.div_fractional;
                end
                bus.inflight <= bus.inflight + 5'(issue) - 5'(retire);
            end
        end
    end
endmodule
